// File: rtl/qd1_request_in_if.sv
// qd1_request_in_if
//   Avalon-MM slave bus bundle for the QD1 request input port.
//   address    : register select (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : registered read data, latency 1 (32 bits)
//   master modport drives the request side, slave modport drives readdata.
interface qd1_request_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/qd1_request_in.sv
// qd1_request_in
//   Avalon-MM slave input port for the QD1 subsystem. Synchronises an
//   external request bus, optionally debounces it, captures edges per bit
//   into a sticky W1C register and raises a level irq on unmasked captures.
//
//   Register map: 0 DATA (RO, filtered level), 1 IRQMASK (RW),
//                 2 EDGECAP (R/W1C), 3 reserved (reads 0).
//
//   Ports:
//     clk      : system clock
//     reset_n  : asynchronous active-low reset
//     bus      : Avalon-MM slave (qd1_request_in_if.slave)
//     in_port  : asynchronous request inputs, WIDTH bits
//     irq      : level interrupt, active high
//
//   Build option: define QD1_REQUEST_IN_DEBOUNCE_EN to insert a per-bit
//   debounce filter (DEBOUNCE_CYCLES stable cycles) after the synchroniser.
module qd1_request_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  qd1_request_in_if.slave  bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [31:0]      f_ext;
  logic [31:0]      mask_ext;
  logic [31:0]      cap_ext;
  logic             wr_en;
  logic             unused_ok;

  // Only the low WIDTH bits of writedata are meaningful; DEBOUNCE_CYCLES
  // is unused when the filter is compiled out.
  assign unused_ok = ^{bus.writedata, 16'(DEBOUNCE_CYCLES)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef QD1_REQUEST_IN_DEBOUNCE_EN
  logic [15:0] cnt [WIDTH];

  // f follows s2 only after s2 has disagreed with it for DEBOUNCE_CYCLES
  // consecutive cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (s2[i] != f[i]) begin
          if (cnt[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
            f[i]   <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 16'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign f = s2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p <= '0;
    else          p <= f;
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = f & ~p;
      1:       edge_det = ~f & p;
      default: edge_det = f ^ p;
    endcase
  end

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign clr   = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;

  // A new edge in the clearing cycle wins over the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~clr) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             irq_mask <= '0;
    else if (wr_en && bus.address == 2'd1)    irq_mask <= bus.writedata[WIDTH-1:0];
  end

  // Zero-extend without a replication count so WIDTH = 32 stays legal.
  always_comb begin
    f_ext                 = '0;
    mask_ext              = '0;
    cap_ext               = '0;
    f_ext[WIDTH-1:0]      = f;
    mask_ext[WIDTH-1:0]   = irq_mask;
    cap_ext[WIDTH-1:0]    = edge_cap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else if (!bus.chipselect) begin
      bus.readdata <= '0;
    end else begin
      case (bus.address)
        2'd0:    bus.readdata <= f_ext;
        2'd1:    bus.readdata <= mask_ext;
        2'd2:    bus.readdata <= cap_ext;
        default: bus.readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_qd1_request_in.sv
module tb_qd1_request_in;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   addr;
  logic         cs;
  logic         wr_n;
  logic [31:0]  wdata;
  logic [W-1:0] in_drv;
  logic         irq0, irq1, irq2;

  qd1_request_in_if bus0 ();
  qd1_request_in_if bus1 ();
  qd1_request_in_if bus2 ();

  assign bus0.address = addr;  assign bus0.chipselect = cs;
  assign bus0.write_n = wr_n;  assign bus0.writedata  = wdata;
  assign bus1.address = addr;  assign bus1.chipselect = cs;
  assign bus1.write_n = wr_n;  assign bus1.writedata  = wdata;
  assign bus2.address = addr;  assign bus2.chipselect = cs;
  assign bus2.write_n = wr_n;  assign bus2.writedata  = wdata;

  qd1_request_in #(.WIDTH(W), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_drv), .irq(irq0));
  qd1_request_in #(.WIDTH(W), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_drv), .irq(irq1));
  qd1_request_in #(.WIDTH(W), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_drv), .irq(irq2));

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b1;

  // Reference model: history of sampled inputs; the filtered level seen
  // before edge n is the input sampled two edges earlier.
  logic [W-1:0] hist[$];
  logic [W-1:0] cap_m [3];
  logic [W-1:0] mask_m;
  logic [31:0]  rd_m [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] edges_of(input int et, input logic [W-1:0] cur, input logic [W-1:0] prev);
    if (et == 0)      return cur & ~prev;
    else if (et == 1) return ~cur & prev;
    else              return cur ^ prev;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
    mask_m = '0;
    for (int t = 0; t < 3; t++) begin
      cap_m[t] = '0;
      rd_m[t]  = '0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] cur, prev, clr_bits;
    cur  = hist[hist.size()-2];
    prev = hist[hist.size()-3];
    clr_bits = (cs && !wr_n && addr == 2'd2) ? wdata[W-1:0] : '0;
    for (int t = 0; t < 3; t++) begin
      rd_m[t] = '0;
      if (cs) begin
        case (addr)
          2'd0:    rd_m[t] = 32'(cur);
          2'd1:    rd_m[t] = 32'(mask_m);
          2'd2:    rd_m[t] = 32'(cap_m[t]);
          default: rd_m[t] = '0;
        endcase
      end
      cap_m[t] = (cap_m[t] & ~clr_bits) | edges_of(t, cur, prev);
    end
    if (cs && !wr_n && addr == 2'd1) mask_m = wdata[W-1:0];
    hist.push_back(in_drv);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic check_all();
    if (model_on) begin
      chk("rd_rise", bus0.readdata, rd_m[0]);
      chk("rd_fall", bus1.readdata, rd_m[1]);
      chk("rd_any",  bus2.readdata, rd_m[2]);
      chk("irq_rise", 32'(irq0), 32'(|(cap_m[0] & mask_m)));
      chk("irq_fall", 32'(irq1), 32'(|(cap_m[1] & mask_m)));
      chk("irq_any",  32'(irq2), 32'(|(cap_m[2] & mask_m)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wr_n = 1'b0; addr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v0, output logic [31:0] v1, output logic [31:0] v2);
    cs = 1'b1; wr_n = 1'b1; addr = a;
    tick();
    v0 = bus0.readdata; v1 = bus1.readdata; v2 = bus2.readdata;
    idle();
  endtask

  logic [31:0] r0, r1, r2, rnd;

  initial begin
    in_drv = '0; addr = '0; wdata = '0;
    idle();
    model_reset();
    reset_n = 1'b0;
    #12;
    chk("reset_rd", bus0.readdata, 32'h0);
    chk("reset_irq", 32'(irq0 | irq1 | irq2), 32'h0);
    reset_n = 1'b1;

`ifndef QD1_REQUEST_IN_DEBOUNCE_EN
    tick(); tick();
    rd(2'd0, r0, r1, r2); chk("reset_data", r0, 32'h0);
    rd(2'd1, r0, r1, r2); chk("reset_mask", r0, 32'h0);
    rd(2'd2, r0, r1, r2); chk("reset_cap", r0, 32'h0);

    // rising capture lands on the third edge after the change
    wr(2'd1, 32'h2);
    in_drv = 4'b0010;
    tick(); chk("rise_e1", 32'(irq0), 32'h0);
    tick(); chk("rise_e2", 32'(irq0), 32'h0);
    tick(); chk("rise_e3", 32'(irq0), 32'h1);
    rd(2'd2, r0, r1, r2); chk("rise_cap", r0, 32'h2);
    rd(2'd0, r0, r1, r2); chk("rise_data", r0, 32'h2);

    // W1C of one bit leaves the other
    in_drv = 4'b0011;
    repeat (3) tick();
    rd(2'd2, r0, r1, r2); chk("cap_0011", r0, 32'h3);
    wr(2'd2, 32'h1);
    rd(2'd2, r0, r1, r2); chk("w1c_bit0", r0, 32'h2);

    // set wins: clear bit1 in the same cycle it captures a new rising edge
    in_drv = 4'b0001;
    repeat (3) tick();
    in_drv = 4'b0011;
    tick(); tick();
    cs = 1'b1; wr_n = 1'b0; addr = 2'd2; wdata = 32'h2;
    tick();
    idle();
    chk("setwin_irq", 32'(irq0), 32'h1);
    rd(2'd2, r0, r1, r2); chk("setwin_cap", r0, 32'h2);
    wr(2'd2, 32'h2);
    rd(2'd2, r0, r1, r2); chk("w1c_bit1", r0, 32'h0);

    // masking
    wr(2'd1, 32'h0);
    in_drv = 4'b1011;
    repeat (3) tick();
    chk("masked_irq", 32'(irq0), 32'h0);
    wr(2'd1, 32'h8);
    chk("unmask_irq", 32'(irq0), 32'h1);
    rd(2'd3, r0, r1, r2); chk("reserved_rd", r0, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd0, r0, r1, r2); chk("data_ro", r0, 32'hB);

    // falling / any on a bit0 pulse
    in_drv = 4'b0000;
    repeat (4) tick();
    wr(2'd2, 32'hF);
    in_drv = 4'b0001;
    repeat (4) tick();
    rd(2'd2, r0, r1, r2);
    chk("pulse_up_rise", r0, 32'h1);
    chk("pulse_up_fall", r1, 32'h0);
    chk("pulse_up_any",  r2, 32'h1);
    wr(2'd2, 32'hF);
    in_drv = 4'b0000;
    repeat (4) tick();
    rd(2'd2, r0, r1, r2);
    chk("pulse_dn_rise", r0, 32'h0);
    chk("pulse_dn_fall", r1, 32'h1);
    chk("pulse_dn_any",  r2, 32'h1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      if (rnd[1:0] == 2'd0) in_drv = rnd[7:4];
      cs    = rnd[8];
      wr_n  = rnd[9] | rnd[10];
      addr  = rnd[12:11];
      wdata = $urandom;
      tick();
    end
    idle();

    // asynchronous reset mid-operation
    wr(2'd1, 32'hF);
    in_drv = 4'b0101;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_rd", bus0.readdata | bus1.readdata | bus2.readdata, 32'h0);
    chk("midrst_irq", 32'(irq0 | irq1 | irq2), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) tick();
    rd(2'd2, r0, r1, r2); chk("post_rst_cap", r0, 32'h5);
    rd(2'd1, r0, r1, r2); chk("post_rst_mask", r0, 32'h0);
`else
    model_on = 1'b0;
    tick(); tick();
    wr(2'd1, 32'h4);
    // a 10-cycle glitch never passes a 16-cycle filter
    in_drv = 4'b0100;
    repeat (10) tick();
    in_drv = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("glitch_irq", 32'(irq0), 32'h0);
    end
    rd(2'd0, r0, r1, r2); chk("glitch_data", r0, 32'h0);
    rd(2'd2, r0, r1, r2); chk("glitch_cap", r0, 32'h0);
    // a stable level is captured 2 + 16 edges after the sampling edge
    in_drv = 4'b0100;
    for (int i = 1; i <= 22; i++) begin
      tick();
      chk("deb_irq", 32'(irq0), (i >= 19) ? 32'h1 : 32'h0);
    end
    rd(2'd0, r0, r1, r2); chk("deb_data", r0, 32'h4);
    rd(2'd2, r0, r1, r2); chk("deb_cap", r0, 32'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
